// File: rtl/eth_rx_frame_parser_if.sv
// Bus interface for eth_rx_frame_parser.
// Groups the receive byte stream, slot-ring control, memory write port, descriptor
// handshake and status counters. The parser connects through the master modport and the
// environment (byte source, memory, descriptor consumer) through the slave modport.
//   rx_dv, rx_data        byte valid / received byte (frame envelope, preamble through FCS)
//   clr_slots, slot_free  slot-ring clear pulse, consumer released oldest slot pulse
//   mem_wr_addr/we/data   slot memory write port, address = {slot, byte offset}
//   busy                  frame in progress
//   desc_*                descriptor valid/ready handshake and fields
//   slots_used            occupied slots
//   drop_count            saturating count of dropped frames
interface eth_rx_frame_parser_if #(
  parameter int unsigned SLOT_COUNT      = 64,
  parameter int unsigned SLOT_BYTES_LOG2 = 10,
  parameter int unsigned ADDR_W          = 16
);
  localparam int unsigned SlotW = $clog2(SLOT_COUNT);

  logic                     rx_dv;
  logic [7:0]               rx_data;
  logic                     clr_slots;
  logic                     slot_free;
  logic [ADDR_W-1:0]        mem_wr_addr;
  logic                     mem_we;
  logic [7:0]               mem_wr_data;
  logic                     busy;
  logic                     desc_valid;
  logic                     desc_ready;
  logic [SlotW-1:0]         desc_slot;
  logic [SLOT_BYTES_LOG2:0] desc_len;
  logic [15:0]              desc_type;
  logic                     desc_bcast;
  logic [SlotW:0]           slots_used;
  logic [15:0]              drop_count;

  modport master (
    input  rx_dv, rx_data, clr_slots, slot_free, desc_ready,
    output mem_wr_addr, mem_we, mem_wr_data, busy, desc_valid, desc_slot, desc_len,
           desc_type, desc_bcast, slots_used, drop_count
  );

  modport slave (
    output rx_dv, rx_data, clr_slots, slot_free, desc_ready,
    input  mem_wr_addr, mem_we, mem_wr_data, busy, desc_valid, desc_slot, desc_len,
           desc_type, desc_bcast, slots_used, drop_count
  );
endinterface

// File: rtl/eth_rx_frame_parser.sv
// Ethernet RX frame parser.
// Takes one reassembled byte per clock, strips preamble/SFD, filters on destination MAC,
// checks the FCS with an inline CRC-32 and writes payload+FCS bytes into a ring of
// fixed-size memory slots. One descriptor (slot, length, type, broadcast) is emitted per
// good frame over a valid/ready handshake. Runt, overflow, ring-full, CRC and
// descriptor-busy drops increment a saturating drop counter.
// Ports:
//   i_eth_clk  rx clock
//   i_rst      synchronous active-high reset
//   bus        eth_rx_frame_parser_if.master (byte stream, ring control, memory write
//              port, descriptor handshake, status)
// Configuration macro:
//   ETH_RX_BCAST_EN  when defined, destination FF:FF:FF:FF:FF:FF is also accepted and
//                    flagged in desc_bcast; otherwise desc_bcast stays 0.
module eth_rx_frame_parser #(
  parameter logic [47:0] MAC_ADDR        = 48'h1A2B3C4D5E6F,
  parameter int unsigned SLOT_COUNT      = 64,
  parameter int unsigned SLOT_BYTES_LOG2 = 10,
  parameter int unsigned ADDR_W          = 16
) (
  input logic                   i_eth_clk,
  input logic                   i_rst,
  eth_rx_frame_parser_if.master bus
);
  localparam int unsigned SlotW = $clog2(SLOT_COUNT);
  localparam int unsigned OffW  = SLOT_BYTES_LOG2 + 1;

  localparam logic [OffW-1:0]  OffLast    = {1'b0, {SLOT_BYTES_LOG2{1'b1}}};
  localparam logic [OffW-1:0]  OffOne     = {{SLOT_BYTES_LOG2{1'b0}}, 1'b1};
  // DEST..FCS minimum is 64 bytes; 14 header bytes are not written, so 50 must be.
  localparam logic [OffW-1:0]  MinWritten = OffW'(50);
  localparam logic [OffW-1:0]  FcsBytes   = OffW'(4);
  localparam logic [SlotW:0]   SlotsFull  = (SlotW + 1)'(SLOT_COUNT);
  localparam logic [SlotW:0]   UsedOne    = {{SlotW{1'b0}}, 1'b1};
  localparam logic [SlotW-1:0] SlotOne    = {{(SlotW - 1){1'b0}}, 1'b1};
  localparam logic [31:0]      CrcInit    = 32'hFFFF_FFFF;
  // Register value after a frame with a correct FCS has been shifted through.
  localparam logic [31:0]      CrcResidue = 32'hC704_DD7B;

  typedef enum logic [3:0] {
    StIdle, StPreamble, StDest, StSrc, StType, StPayload, StCheck, StCommit, StDrop
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  logic [39:0]       dest_q, dest_d;
  logic [15:0]       type_q, type_d;
  logic [31:0]       crc_q, crc_d, crc_next;
  logic [OffW-1:0]   offset_q, offset_d;
  logic [SlotW-1:0]  wr_slot_q, wr_slot_d;
  logic [SlotW:0]    used_q, used_d;
  logic [15:0]       drop_q, drop_d;
  logic              clr_pend_q, clr_pend_d;
  logic              ign_q, ign_d;
  logic              bcast_q, bcast_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              desc_valid_q, desc_valid_d;
  logic [SlotW-1:0]  desc_slot_q, desc_slot_d;
  logic [OffW-1:0]   desc_len_q, desc_len_d;
  logic [15:0]       desc_type_q, desc_type_d;
  logic              desc_bcast_q, desc_bcast_d;

  logic              drop_inc;
  logic              commit;
  logic              clr_apply;
  logic              free_ok;
  logic [47:0]       dest_shift;
  logic              dest_bcast;
  logic              dest_ok;

  // CRC-32, poly 04C11DB7, register MSB-first, data bits fed LSB first (reflected input).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) begin
        r = (r << 1) ^ 32'h04C1_1DB7;
      end else begin
        r = r << 1;
      end
    end
    return r;
  endfunction

  assign crc_next   = crc_byte(crc_q, bus.rx_data);
  assign dest_shift = {dest_q, bus.rx_data};

`ifdef ETH_RX_BCAST_EN
  assign dest_bcast = (dest_shift == 48'hFFFF_FFFF_FFFF);
`else
  assign dest_bcast = 1'b0;
`endif
  assign dest_ok = (dest_shift == MAC_ADDR) || dest_bcast;

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    dest_d       = dest_q;
    type_d       = type_q;
    crc_d        = crc_q;
    offset_d     = offset_q;
    wr_slot_d    = wr_slot_q;
    clr_pend_d   = clr_pend_q | bus.clr_slots;
    ign_d        = ign_q;
    bcast_d      = bcast_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    desc_valid_d = desc_valid_q & ~bus.desc_ready;
    desc_slot_d  = desc_slot_q;
    desc_len_d   = desc_len_q;
    desc_type_d  = desc_type_q;
    desc_bcast_d = desc_bcast_q;
    drop_inc     = 1'b0;
    commit       = 1'b0;
    clr_apply    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr_pend_d) begin
          clr_apply  = 1'b1;
          clr_pend_d = 1'b0;
          wr_slot_d  = '0;
        end
        // A burst that does not open with 55 is ignored until dv drops.
        if (!bus.rx_dv) begin
          ign_d = 1'b0;
        end else if (!ign_q) begin
          if (bus.rx_data == 8'h55) begin
            state_d = StPreamble;
          end else begin
            ign_d = 1'b1;
          end
        end
      end

      StPreamble: begin
        if (!bus.rx_dv) begin
          state_d = StIdle;
        end else if (bus.rx_data == 8'hD5) begin
          if (used_q == SlotsFull) begin
            state_d  = StDrop;
            drop_inc = 1'b1;
          end else begin
            state_d   = StDest;
            hdr_cnt_d = '0;
            crc_d     = CrcInit;
            offset_d  = '0;
          end
        end else if (bus.rx_data != 8'h55) begin
          state_d = StDrop;
        end
      end

      StDest, StSrc, StType: begin
        if (!bus.rx_dv) begin
          state_d  = StIdle;
          drop_inc = 1'b1;
        end else begin
          crc_d     = crc_next;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (state_q == StDest) begin
            dest_d = dest_shift[39:0];
          end
          if (state_q == StType) begin
            type_d = {type_q[7:0], bus.rx_data};
          end
          if (state_q == StDest && hdr_cnt_q == 3'd5) begin
            hdr_cnt_d = '0;
            if (dest_ok) begin
              state_d = StSrc;
              bcast_d = dest_bcast;
            end else begin
              // Not addressed to us: silent drop.
              state_d = StDrop;
            end
          end else if (state_q == StSrc && hdr_cnt_q == 3'd5) begin
            hdr_cnt_d = '0;
            state_d   = StType;
          end else if (state_q == StType && hdr_cnt_q == 3'd1) begin
            hdr_cnt_d = '0;
            state_d   = StPayload;
          end
        end
      end

      StPayload: begin
        if (!bus.rx_dv) begin
          state_d = StCheck;
        end else begin
          crc_d      = crc_next;
          mem_we_d   = 1'b1;
          mem_addr_d = {wr_slot_q, offset_q[SLOT_BYTES_LOG2-1:0]};
          mem_data_d = bus.rx_data;
          offset_d   = offset_q + OffOne;
          if (offset_q == OffLast) begin
            // Slot is full; the frame cannot be kept.
            state_d  = StDrop;
            drop_inc = 1'b1;
          end
        end
      end

      StCheck: begin
        if (offset_q < MinWritten || crc_q != CrcResidue) begin
          state_d  = StIdle;
          drop_inc = 1'b1;
        end else begin
          state_d = StCommit;
        end
      end

      StCommit: begin
        state_d = StIdle;
        if (desc_valid_q && !bus.desc_ready) begin
          drop_inc = 1'b1;
        end else begin
          commit       = 1'b1;
          desc_valid_d = 1'b1;
          desc_slot_d  = wr_slot_q;
          desc_len_d   = offset_q - FcsBytes;
          desc_type_d  = type_q;
          desc_bcast_d = bcast_q;
          wr_slot_d    = wr_slot_q + SlotOne;
        end
      end

      StDrop: begin
        if (!bus.rx_dv) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Occupancy: a release on an empty ring is ignored, commit plus release cancel out.
  assign free_ok = bus.slot_free && (used_q != '0);

  always_comb begin
    used_d = used_q;
    if (clr_apply) begin
      used_d = '0;
    end else if (commit && !free_ok) begin
      used_d = used_q + UsedOne;
    end else if (!commit && free_ok) begin
      used_d = used_q - UsedOne;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_inc && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      hdr_cnt_q    <= '0;
      dest_q       <= '0;
      type_q       <= '0;
      crc_q        <= CrcInit;
      offset_q     <= '0;
      wr_slot_q    <= '0;
      used_q       <= '0;
      drop_q       <= '0;
      clr_pend_q   <= 1'b0;
      ign_q        <= 1'b0;
      bcast_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      desc_valid_q <= 1'b0;
      desc_slot_q  <= '0;
      desc_len_q   <= '0;
      desc_type_q  <= '0;
      desc_bcast_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      dest_q       <= dest_d;
      type_q       <= type_d;
      crc_q        <= crc_d;
      offset_q     <= offset_d;
      wr_slot_q    <= wr_slot_d;
      used_q       <= used_d;
      drop_q       <= drop_d;
      clr_pend_q   <= clr_pend_d;
      ign_q        <= ign_d;
      bcast_q      <= bcast_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      desc_valid_q <= desc_valid_d;
      desc_slot_q  <= desc_slot_d;
      desc_len_q   <= desc_len_d;
      desc_type_q  <= desc_type_d;
      desc_bcast_q <= desc_bcast_d;
    end
  end

  assign bus.mem_wr_addr = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wr_data = mem_data_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.desc_valid  = desc_valid_q;
  assign bus.desc_slot   = desc_slot_q;
  assign bus.desc_len    = desc_len_q;
  assign bus.desc_type   = desc_type_q;
  assign bus.desc_bcast  = desc_bcast_q;
  assign bus.slots_used  = used_q;
  assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Randomized self-checking bench for eth_rx_frame_parser against a frame-level model.
module tb_eth_rx_frame_parser;
  localparam logic [47:0] MacAddr   = 48'h1A2B3C4D5E6F;
  localparam logic [47:0] OtherMac  = 48'h020000000001;
  localparam logic [47:0] BcastMac  = 48'hFFFFFFFFFFFF;
  localparam int          SlotCount = 64;
  localparam int          SlotBytes = 1024;
`ifdef ETH_RX_BCAST_EN
  localparam bit BcastEn = 1'b1;
`else
  localparam bit BcastEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_rx_frame_parser_if #(.SLOT_COUNT(64), .SLOT_BYTES_LOG2(10), .ADDR_W(16)) bus ();

  eth_rx_frame_parser #(
    .MAC_ADDR(MacAddr), .SLOT_COUNT(64), .SLOT_BYTES_LOG2(10), .ADDR_W(16)
  ) dut (
    .i_eth_clk(clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int m_slot, m_used, m_drop;
  bit m_pending;
  logic [31:0] exp_wr_q[$];
  logic [63:0] exp_desc_q[$];
  // observed
  logic [31:0] wr_q[$];
  logic [63:0] desc_q[$];
  // frame under construction
  logic [7:0]  wire_q[$];
  logic [7:0]  body_q[$];
  int          probe_idx = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) wr_q.push_back({8'h00, bus.mem_wr_addr, bus.mem_wr_data});
      if (bus.desc_valid && bus.desc_ready)
        desc_q.push_back({30'h0, bus.desc_bcast, bus.desc_type, bus.desc_len, bus.desc_slot});
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic put(input logic dv, input logic [7:0] d);
    bus.rx_dv   = dv;
    bus.rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 8'h00);
  endtask

  task automatic drop_one();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic slot_free_pulse();
    bus.slot_free = 1'b1;
    put(1'b0, 8'h00);
    bus.slot_free = 1'b0;
    if (m_used > 0) m_used--;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_dv = 1'b0; bus.rx_data = 8'h00; bus.clr_slots = 1'b0;
    bus.slot_free = 1'b0; bus.desc_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_slot = 0; m_used = 0; m_drop = 0; m_pending = 1'b0;
    exp_wr_q.delete(); exp_desc_q.delete(); wr_q.delete(); desc_q.delete();
  endtask

  // Frame-level outcome: which bytes land where, and whether a descriptor appears.
  task automatic model_frame(input logic [47:0] dest, input logic [15:0] typ, input bit bad,
                             input bit clr);
    bit bc, ours;
    int n, nw;
    bc   = BcastEn && (dest == BcastMac);
    ours = (dest == MacAddr) || bc;
    n    = body_q.size();
    if (m_used == SlotCount) begin
      drop_one();
    end else if (ours) begin
      nw = (n >= SlotBytes) ? SlotBytes : n;
      for (int i = 0; i < nw; i++)
        exp_wr_q.push_back({8'h00, 16'(m_slot * SlotBytes + i), body_q[i]});
      if (n >= SlotBytes || n + 14 < 64 || bad || m_pending) begin
        drop_one();
      end else begin
        exp_desc_q.push_back({30'h0, bc, typ, 11'(n - 4), 6'(m_slot)});
        m_slot = (m_slot + 1) % SlotCount;
        m_used++;
        if (!bus.desc_ready) m_pending = 1'b1;
      end
    end
    if (clr) begin
      m_slot = 0;
      m_used = 0;
    end
  endtask

  // Drives the whole frame; returns right after the last FCS byte is sampled.
  task automatic send_frame(input logic [47:0] dest, input int pl, input bit bad,
                            input int clr_at);
    logic [31:0] c;
    logic [15:0] typ;
    logic [7:0]  b;
    wire_q.delete();
    body_q.delete();
    typ = 16'($urandom);
    c   = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) wire_q.push_back(8'h55);
    wire_q.push_back(8'hD5);
    for (int i = 0; i < 14; i++) begin
      if (i < 6)       b = dest[47-8*i -: 8];
      else if (i < 12) b = 8'($urandom);
      else if (i == 12) b = typ[15:8];
      else             b = typ[7:0];
      wire_q.push_back(b);
      c = crc_step(c, b);
    end
    for (int i = 0; i < pl; i++) begin
      b = 8'($urandom);
      wire_q.push_back(b);
      body_q.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    if (bad) c[31:24] = c[31:24] ^ 8'h01;
    for (int i = 0; i < 4; i++) begin
      wire_q.push_back(c[8*i +: 8]);
      body_q.push_back(c[8*i +: 8]);
    end
    model_frame(dest, typ, bad, clr_at >= 0);
    for (int k = 0; k < wire_q.size(); k++) begin
      bus.clr_slots = (k == clr_at);
      put(1'b1, wire_q[k]);
      if (k == probe_idx) begin
        check("first_wr_we", bus.mem_we, 1'b1);
        check("first_wr_data", bus.mem_wr_data, wire_q[k]);
      end
    end
    bus.clr_slots = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, ":nwr"}, wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < exp_wr_q.size() && i < wr_q.size(); i++)
      check({tag, ":wr"}, wr_q[i], exp_wr_q[i]);
    check({tag, ":ndesc"}, desc_q.size(), exp_desc_q.size());
    for (int i = 0; i < exp_desc_q.size() && i < desc_q.size(); i++)
      check({tag, ":desc"}, desc_q[i], exp_desc_q[i]);
    check({tag, ":drops"}, bus.drop_count, m_drop);
    check({tag, ":used"}, bus.slots_used, m_used);
    wr_q.delete(); exp_wr_q.delete(); desc_q.delete(); exp_desc_q.delete();
  endtask

  task automatic frame(input string tag, input logic [47:0] dest, input int pl, input bit bad);
    send_frame(dest, pl, bad, -1);
    idle(10);
    check_frame(tag);
  endtask

  initial begin
    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_wr_addr, 0);
    check("rst_data", bus.mem_wr_data, 0);
    check("rst_dvalid", bus.desc_valid, 0);
    check("rst_dslot", bus.desc_slot, 0);
    check("rst_dlen", bus.desc_len, 0);
    check("rst_dtype", bus.desc_type, 0);
    check("rst_dbcast", bus.desc_bcast, 0);
    check("rst_used", bus.slots_used, 0);
    check("rst_drops", bus.drop_count, 0);

    // minimum good frame with latency probes
    probe_idx = 22;
    send_frame(MacAddr, 46, 1'b0, -1);
    probe_idx = -1;
    put(1'b0, 8'h00);
    check("t1_busy_check", bus.busy, 1);
    check("t1_dv_e0", bus.desc_valid, 0);
    put(1'b0, 8'h00);
    check("t1_dv_e1", bus.desc_valid, 0);
    put(1'b0, 8'h00);
    check("t1_dv_e2", bus.desc_valid, 1);
    check("t1_slot", bus.desc_slot, 0);
    check("t1_len", bus.desc_len, 46);
    check("t1_used", bus.slots_used, 1);
    idle(8);
    check_frame("t1");

    // bad FCS, then slot reuse
    do_reset();
    frame("t2_bad", MacAddr, 46, 1'b1);
    frame("t2_reuse", MacAddr, 46, 1'b0);

    // foreign destination
    send_frame(OtherMac, 46, 1'b0, -1);
    check("t3_busy_drop", bus.busy, 1);
    put(1'b0, 8'h00);
    check("t3_busy_low", bus.busy, 0);
    idle(8);
    check_frame("t3");

    // dv falls inside the destination field
    for (int i = 0; i < 7; i++) put(1'b1, 8'h55);
    put(1'b1, 8'hD5);
    for (int i = 0; i < 5; i++) put(1'b1, MacAddr[47-8*i -: 8]);
    put(1'b0, 8'h00);
    check("hdr_runt_busy", bus.busy, 0);
    drop_one();
    idle(8);
    check_frame("hdr_runt");

    frame("runt63", MacAddr, 45, 1'b0);
    frame("overflow", MacAddr, 1100, 1'b0);
    frame("after_ovf", MacAddr, 60, 1'b0);

    // descriptor held while consumer stalls; second frame dropped
    bus.desc_ready = 1'b0;
    send_frame(MacAddr, 50, 1'b0, -1);
    idle(6);
    check("pend_valid", bus.desc_valid, 1);
    check("pend_hold_a", {30'h0, bus.desc_bcast, bus.desc_type, bus.desc_len, bus.desc_slot},
          exp_desc_q[exp_desc_q.size()-1]);
    send_frame(MacAddr, 70, 1'b0, -1);
    idle(6);
    check("pend_hold_b", {30'h0, bus.desc_bcast, bus.desc_type, bus.desc_len, bus.desc_slot},
          exp_desc_q[exp_desc_q.size()-1]);
    bus.desc_ready = 1'b1;
    m_pending = 1'b0;
    idle(4);
    check_frame("pend");

    frame("bcast", BcastMac, 60, 1'b0);

    // clear requested mid-frame takes effect once idle
    send_frame(MacAddr, 50, 1'b0, 20);
    idle(10);
    check_frame("clr");
    frame("after_clr", MacAddr, 46, 1'b0);

    for (int f = 0; f < 24; f++) begin
      int sel;
      logic [47:0] d;
      sel = int'($urandom_range(0, 4));
      d = (sel <= 2) ? MacAddr : (sel == 3) ? OtherMac : BcastMac;
      send_frame(d, int'($urandom_range(40, 140)), ($urandom_range(0, 4) == 0), -1);
      idle(10);
      check_frame("rand");
      if ($urandom_range(0, 2) == 0) slot_free_pulse();
    end

    // fill the whole ring
    do_reset();
    for (int f = 0; f < SlotCount; f++) frame("fill", MacAddr, 46, 1'b0);
    check("full_used", bus.slots_used, 64);
    frame("full_drop", MacAddr, 46, 1'b0);
    slot_free_pulse();
    frame("wrap", MacAddr, 46, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
